// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//
// Shares one combinational ALU between two issue requesters:
//   channel 0 : integer pipe
//   channel 1 : branch/CSR unit
//
// Each cycle at most one request is granted, chosen round-robin. The winner's
// operands and operation are driven to the ALU. The ALU result is captured in
// a one-entry output register, together with the winner's tag and channel id.
// The output register uses a valid/ready handshake.
//
// Ports
//   clk, rst                     clock and synchronous active-high reset
//   inN_valid / inN_ready        request handshake for channel N (N = 0, 1)
//   inN_op1, inN_op2             32-bit operands for channel N
//   inN_alu_ops                  5-bit ALU operation for channel N
//   inN_tag                      TAG_W-bit requester tag for channel N
//   alu_op1, alu_op2, alu_ops    drive to the shared combinational ALU
//   alu_out                      combinational ALU result
//   out_valid / out_ready        result handshake
//   out_data                     registered ALU result
//   out_tag                      tag of the registered result
//   out_src                      channel that produced the result
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [31:0]      in0_op1,
    input  logic [31:0]      in0_op2,
    input  logic [4:0]       in0_alu_ops,
    input  logic [TAG_W-1:0] in0_tag,

    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [31:0]      in1_op1,
    input  logic [31:0]      in1_op2,
    input  logic [4:0]       in1_alu_ops,
    input  logic [TAG_W-1:0] in1_tag,

    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [4:0]       alu_ops,
    input  logic [31:0]      alu_out,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
);

    logic             prio_r;        // favored channel when both request
    logic             can_accept_s;  // output register empty or draining now
    logic             grant_vld_s;   // a request is granted this cycle
    logic             grant_s;       // which channel is granted
    logic [TAG_W-1:0] grant_tag_s;   // tag of the granted channel

    // Output slot is free when empty or when being consumed in this cycle.
    assign can_accept_s = ~out_valid | out_ready;

    // Round-robin grant selection; nothing is granted while in reset.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
        if (rst) begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
        end else if (can_accept_s) begin
            case ({in1_valid, in0_valid})
                2'b11: begin
                    grant_vld_s = 1'b1;
                    grant_s     = prio_r;
                end
                2'b01: begin
                    grant_vld_s = 1'b1;
                    grant_s     = 1'b0;
                end
                2'b10: begin
                    grant_vld_s = 1'b1;
                    grant_s     = 1'b1;
                end
                default: begin
                    grant_vld_s = 1'b0;
                    grant_s     = 1'b0;
                end
            endcase
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
        end
    end

    // Ready is the grant itself, so at most one channel sees ready.
    assign in0_ready = grant_vld_s & (grant_s == 1'b0);
    assign in1_ready = grant_vld_s & (grant_s == 1'b1);

    // ALU operand/operation mux; forced to zero when nothing is granted.
    always_comb begin
        alu_op1     = 32'd0;
        alu_op2     = 32'd0;
        alu_ops     = 5'd0;
        grant_tag_s = '0;
        if (in0_ready) begin
            alu_op1     = in0_op1;
            alu_op2     = in0_op2;
            alu_ops     = in0_alu_ops;
            grant_tag_s = in0_tag;
        end else if (in1_ready) begin
            alu_op1     = in1_op1;
            alu_op2     = in1_op2;
            alu_ops     = in1_alu_ops;
            grant_tag_s = in1_tag;
        end else begin
            alu_op1     = 32'd0;
            alu_op2     = 32'd0;
            alu_ops     = 5'd0;
            grant_tag_s = '0;
        end
    end

    // Result register and round-robin pointer. A new grant overwrites any
    // result drained in the same edge; a drain without a grant only clears
    // valid, leaving the payload in place. Reset drops any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_tag   <= '0;
            out_src   <= 1'b0;
            prio_r    <= 1'b0;
        end else if (grant_vld_s) begin
            out_valid <= 1'b1;
            out_data  <= alu_out;
            out_tag   <= grant_tag_s;
            out_src   <= grant_s;
            prio_r    <= ~grant_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arbiter
//
// Directed bench for alu_issue_arbiter. A small behavioural ALU answers the
// arbiter's alu_* drive; every expected value below is a hand-computed
// constant.
// -----------------------------------------------------------------------------
module tb_alu_issue_arbiter;

    localparam int TAG_W = 4;

    // Operation codes used by the bench ALU model.
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_SLT = 5'd2;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd13;

    logic             clk;
    logic             rst;
    logic             in0_valid, in0_ready;
    logic [31:0]      in0_op1, in0_op2;
    logic [4:0]       in0_alu_ops;
    logic [TAG_W-1:0] in0_tag;
    logic             in1_valid, in1_ready;
    logic [31:0]      in1_op1, in1_op2;
    logic [4:0]       in1_alu_ops;
    logic [TAG_W-1:0] in1_tag;
    logic [31:0]      alu_op1, alu_op2;
    logic [4:0]       alu_ops;
    logic [31:0]      alu_out;
    logic             out_valid, out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_src;

    int checks;
    int failures;

    alu_issue_arbiter #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in0_valid   (in0_valid),
        .in0_ready   (in0_ready),
        .in0_op1     (in0_op1),
        .in0_op2     (in0_op2),
        .in0_alu_ops (in0_alu_ops),
        .in0_tag     (in0_tag),
        .in1_valid   (in1_valid),
        .in1_ready   (in1_ready),
        .in1_op1     (in1_op1),
        .in1_op2     (in1_op2),
        .in1_alu_ops (in1_alu_ops),
        .in1_tag     (in1_tag),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_ops     (alu_ops),
        .alu_out     (alu_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_src     (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU.
    always_comb begin
        alu_out = 32'd0;
        case (alu_ops)
            OP_ADD:  alu_out = alu_op1 + alu_op2;
            OP_SUB:  alu_out = alu_op1 - alu_op2;
            OP_SLT:  alu_out = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
            OP_XOR:  alu_out = alu_op1 ^ alu_op2;
            OP_SRA:  alu_out = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
            default: alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
        in0_valid = v; in0_alu_ops = op; in0_op1 = a; in0_op2 = b; in0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
        in1_valid = v; in1_alu_ops = op; in1_op1 = a; in1_op2 = b; in1_tag = t;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        set0(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
        set1(1'b1, OP_XOR, 32'hF0, 32'h0F, 4'd2);
        #1;
        // During reset nothing is granted even with requests present.
        chk("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
        chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_ops", {27'd0, alu_ops}, 32'd0);
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_out_src", {31'd0, out_src}, 32'd0);

        // --- ch0 ADD 5+7 tag 3 ---
        set1(1'b0, OP_XOR, 32'hF0, 32'h0F, 4'd2);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("add_in0_ready", {31'd0, in0_ready}, 32'd1);
        chk("add_in1_ready", {31'd0, in1_ready}, 32'd0);
        chk("add_alu_op1", alu_op1, 32'd5);
        chk("add_alu_op2", alu_op2, 32'd7);
        tick();
        set0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_out_data", out_data, 32'd12);
        chk("add_out_tag", {28'd0, out_tag}, 32'd3);
        chk("add_out_src", {31'd0, out_src}, 32'd0);
        // prio now favors ch1: a contended cycle must go to ch1.
        set0(1'b1, OP_SUB, 32'd10, 32'd3, 4'd1);
        set1(1'b1, OP_XOR, 32'hF0, 32'h0F, 4'd2);
        #1;
        chk("prio1_in1_ready", {31'd0, in1_ready}, 32'd1);
        chk("prio1_in0_ready", {31'd0, in0_ready}, 32'd0);

        // Reset again so the alternation starts at ch0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        // --- both valid for 4 cycles: 7(src0), FF(src1), 7(src0), FF(src1) ---
        for (int i = 0; i < 4; i++) begin
            chk("rr_in0_ready", {31'd0, in0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_in1_ready", {31'd0, in1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr_out_data", out_data, (i % 2 == 0) ? 32'd7 : 32'hFF);
            chk("rr_out_src", {31'd0, out_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_out_tag", {28'd0, out_tag}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_out_valid", {31'd0, out_valid}, 32'd1);
        end

        // --- stall: FF pending, out_ready=0, ch1 ADD 100+1 tag 5 waits ---
        set0(1'b0, OP_SUB, 32'd0, 32'd0, 4'd0);
        set1(1'b1, OP_ADD, 32'd100, 32'd1, 4'd5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in1_ready", {31'd0, in1_ready}, 32'd0);
            chk("stall_alu_op1", alu_op1, 32'd0);
            tick();
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_data", out_data, 32'hFF);
            chk("stall_out_src", {31'd0, out_src}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in1_ready", {31'd0, in1_ready}, 32'd1);
        tick();
        set1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        chk("unstall_out_data", out_data, 32'd101);
        chk("unstall_out_tag", {28'd0, out_tag}, 32'd5);
        chk("unstall_out_src", {31'd0, out_src}, 32'd1);

        // --- drain and issue together: ch0 SLT -1 < 1 ---
        set0(1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1, 4'd6);
        #1;
        chk("slt_in0_ready", {31'd0, in0_ready}, 32'd1);
        tick();
        set0(1'b0, OP_SLT, 32'd0, 32'd0, 4'd0);
        chk("slt_out_valid", {31'd0, out_valid}, 32'd1);
        chk("slt_out_data", out_data, 32'd1);
        chk("slt_out_tag", {28'd0, out_tag}, 32'd6);

        // --- ch1 alone SRA 0x80000000 >>> 4 ---
        set1(1'b1, OP_SRA, 32'h80000000, 32'd4, 4'd7);
        tick();
        chk("sra_out_data", out_data, 32'hF8000000);
        chk("sra_out_src", {31'd0, out_src}, 32'd1);
        // prio returned to ch0.
        set0(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
        set1(1'b1, OP_XOR, 32'hF0, 32'h0F, 4'd2);
        #1;
        chk("after_sra_in0_ready", {31'd0, in0_ready}, 32'd1);
        chk("after_sra_in1_ready", {31'd0, in1_ready}, 32'd0);
        tick();
        chk("after_sra_out_data", out_data, 32'd12);

        // --- drain without issue: valid clears, payload holds ---
        set0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        set1(1'b0, OP_XOR, 32'd0, 32'd0, 4'd0);
        tick();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_out_data", out_data, 32'd12);
        chk("drain_out_tag", {28'd0, out_tag}, 32'd3);

        // --- reset mid-stall drops the pending result ---
        set1(1'b1, OP_XOR, 32'hF0, 32'h0F, 4'd2);
        tick();
        set1(1'b0, OP_XOR, 32'd0, 32'd0, 4'd0);
        out_ready = 1'b0;
        chk("pend_out_valid", {31'd0, out_valid}, 32'd1);
        chk("pend_out_data", out_data, 32'hFF);
        set0(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst2_in0_ready", {31'd0, in0_ready}, 32'd0);
        chk("rst2_alu_op1", alu_op1, 32'd0);
        tick();
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_out_data", out_data, 32'd0);
        chk("rst2_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst2_out_src", {31'd0, out_src}, 32'd0);
        rst = 1'b0;
        set1(1'b1, OP_XOR, 32'hF0, 32'h0F, 4'd2);
        #1;
        chk("rst2_prio_in0_ready", {31'd0, in0_ready}, 32'd1);
        chk("rst2_prio_in1_ready", {31'd0, in1_ready}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single combinational ALU (`execute`) between two issue requesters: channel 0 (integer pipe) and channel 1 (branch/CSR unit). Each cycle it grants at most one request by round-robin and drives the winner's operands and `alu_ops` onto the ALU. It captures the ALU result in a one-entry output register with a valid/ready handshake, tagged with the requester's tag and source id. It sits between the issue stage and writeback/branch resolution.

## Interface
Parameters:
- `TAG_W`, 4, width of the requester-supplied tag carried with each operation.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in0_valid`  in  1  channel 0 request valid.
- `in0_ready`  out  1  channel 0 request accepted this cycle.
- `in0_op1`, `in0_op2`  in  32 each  channel 0 operands.
- `in0_alu_ops`  in  5  channel 0 ALU operation, `common` package encoding.
- `in0_tag`  in  TAG_W  channel 0 tag.
- `in1_valid`, `in1_ready`, `in1_op1`, `in1_op2`, `in1_alu_ops`, `in1_tag`  same as channel 0, for channel 1.
- `alu_op1`, `alu_op2`  out  32 each  operands to the ALU.
- `alu_ops`  out  5  operation to the ALU.
- `alu_out`  in  32  combinational ALU result.
- `out_valid`  out  1  result register holds a valid result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  registered ALU result.
- `out_tag`  out  TAG_W  tag of the registered result.
- `out_src`  out  1  requester that produced the result (0 or 1).

## Operation
- `can_accept = !out_valid || out_ready`. The arbiter issues only when the output register is empty or is being drained in the same cycle.
- Priority pointer `prio` (1 bit, internal) selects the favored channel.
- Grant rules, evaluated only when `can_accept`:
  - both channels valid: grant `prio`.
  - exactly one channel valid: grant that channel.
  - neither valid: no grant.
- `inN_ready = can_accept && grant==N`. At most one ready is high per cycle.
- `inN_ready` may depend combinationally on both `in*_valid`. Requesters must not make `valid` depend on `ready`. A requester holds valid, operands, op and tag stable until accepted.
- ALU drive:
  - on grant: `alu_op1`, `alu_op2` and `alu_ops` come from the granted channel.
  - no grant: all three are zero.
- On a grant, at the clock edge:
  - `out_data` captures `alu_out`, `out_tag` captures the granted tag, `out_src` captures the granted channel.
  - `out_valid` is set to 1.
  - `prio` is set to the other channel (`prio <= ~grant`), even when only one channel requested.
- `out_ready` with no grant: `out_valid` clears. `out_data`, `out_tag` and `out_src` hold their values.
- Output stall (`out_valid && !out_ready`): the output register and `prio` hold, and both ready signals are 0.
- Simultaneous drain and issue: the new result replaces the old one in the same edge, and `out_valid` stays 1.
- Reset (at any point, including mid-stall): a pending result is dropped, not delivered.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_tag`=0, `out_src`=0, `prio`=0 (channel 0 favored).
- While `rst` is high: `in0_ready`=`in1_ready`=0 and `alu_*`=0.
- Latency: a request accepted at edge N is visible on the `out_*` ports after edge N, i.e. one cycle.
- Throughput: one result per cycle while `out_ready` is held high.
- Fairness: with both channels continuously valid and `out_ready`=1, grants alternate 0,1,0,1,... starting with 0 after reset. A requester waits at most one grant.
- No combinational path exists from `out_ready` to `out_data`. A combinational path from `out_ready` to `in*_ready` and `alu_*` exists by design.

## Test plan
- Reset, then ch0 issues ADD with op1=5, op2=7, tag=3 -> `in0_ready`=1 that cycle; next cycle `out_valid`=1, `out_data`=12, `out_tag`=3, `out_src`=0; `prio`=1.
- Both channels valid for 4 cycles (ch0 SUB 10-3, ch1 XOR F0^0F), `out_ready`=1 -> results in order 7(src0), FF(src1), 7(src0), FF(src1).
- Result pending with `out_ready`=0 for 3 cycles while ch1 is valid -> `in1_ready`=0 and `out_*` stable; `out_ready`=1 -> ch1 granted in that cycle, its result appears the next cycle.
- Drain and issue in the same cycle (SLT op1=FFFFFFFF, op2=1) -> `out_valid` stays 1, `out_data` becomes 1, no bubble.
- Ch1 alone issues SRA op1=80000000, op2=4 -> `out_data`=F8000000, `out_src`=1, `prio`=0; then ch0 and ch1 both valid -> ch0 granted.
- `rst` asserted while `out_valid`=1 and `out_ready`=0 -> next cycle `out_valid`=0, all `out_*`=0, `prio`=0, both readies 0 during reset.
